tx_frame_ctrl: RTL

// - Frame sequencer ahead of the spread-spectrum transmitter. Takes a payload byte stream from the host
//   (valid/ready) and emits one serial frame bit per bit period on tx_bit/tx_en into transmitter.data_i.
// - Frame layout: preamble, sync word, length byte, payload, guard. The receiver uses the preamble and

---
 rtl/tx_frame_ctrl_pkg.sv | 35 +++
 rtl/tx_frame_ctrl_bit_timer.sv | 30 +++
 rtl/tx_frame_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_ctrl_pkg.sv
// Shared state encodings, default sync byte and width helpers
// for the transmit frame sequencer.
package tx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SYNC  = 3'd2,
        ST_LEN   = 3'd3,
        ST_PAY   = 3'd4,
        ST_GUARD = 3'd5
    } state_t;

    localparam logic [7:0] DEF_SYNC_WORD = 8'hD5;
    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bit counter must reach the longest field length minus one.
    function automatic int unsigned bit_cnt_w(
        input int unsigned pre_len,
        input int unsigned guard_len
    );
        return $clog2(max3(pre_len, guard_len, BYTE_W) + 1);
    endfunction

endpackage

// File: rtl/tx_frame_ctrl_bit_timer.sv
// Bit-period divider: counts clk cycles within a frame bit and
// strobes bit_end on the last cycle of each bit.
module tx_frame_ctrl_bit_timer #(
    parameter int unsigned BIT_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_end
);

    localparam int unsigned DIV_W = $clog2(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Count while a frame is active; park at zero otherwise
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign bit_end = run && (div_cnt == DIV_LAST);

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer: preamble, sync, length, payload and guard bits
// serialised one bit per bit period toward the transmitter.
module tx_frame_ctrl
    import tx_frame_ctrl_pkg::*;
#(
    parameter int unsigned BIT_DIV   = 16,
    parameter int unsigned PRE_LEN   = 16,
    parameter logic [7:0]  SYNC_WORD = DEF_SYNC_WORD,
    parameter int unsigned GUARD_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx_bit,
    output logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int unsigned BC_W = bit_cnt_w(PRE_LEN, GUARD_LEN);
    localparam logic [BC_W-1:0] PRE_LAST   = BC_W'(PRE_LEN - 1);
    localparam logic [BC_W-1:0] GUARD_LAST = BC_W'(GUARD_LEN - 1);
    localparam logic [BC_W-1:0] BYTE_LAST  = BC_W'(BYTE_W - 1);

    state_t          state;
    logic [BC_W-1:0] bit_cnt;
    logic [7:0]      len_r;
    logic [7:0]      shreg;
    logic [7:0]      hold;
    logic            hold_full;
    logic [7:0]      bytes_acc;
    logic [7:0]      pay_cnt;

    logic       bit_end;
    logic       accept;
    logic       last_bit;
    logic       at_boundary;
    logic       have_byte;
    logic [7:0] next_byte;

    tx_frame_ctrl_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state != ST_IDLE),
        .bit_end (bit_end)
    );

    // Hold slot is open only while payload may still be needed
    assign byte_ready = !hold_full
                     && (bytes_acc < len_r)
                     && (state inside {ST_PRE, ST_SYNC, ST_LEN, ST_PAY});

    assign accept      = byte_valid && byte_ready;
    assign last_bit    = bit_end && (bit_cnt == BYTE_LAST);
    assign at_boundary = last_bit
                      && (((state == ST_LEN) && (len_r != 8'd0))
                       || ((state == ST_PAY) && (pay_cnt != len_r)));
    assign have_byte   = hold_full || accept;
    assign next_byte   = hold_full ? hold : byte_data;

    // Frame FSM with shifter, holding buffer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            len_r     <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bytes_acc <= '0;
            pay_cnt   <= '0;
            tx_bit    <= 1'b0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                bytes_acc <= bytes_acc + 8'd1;
            end
            if (at_boundary) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold      <= byte_data;
                hold_full <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_PRE;
                        bit_cnt   <= '0;
                        len_r     <= len;
                        bytes_acc <= '0;
                        pay_cnt   <= '0;
                        hold_full <= 1'b0;
                        underrun  <= 1'b0;
                        tx_bit    <= 1'b1;
                        tx_en     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (bit_end) begin
                        if (bit_cnt == PRE_LAST) begin
                            state   <= ST_SYNC;
                            bit_cnt <= '0;
                            shreg   <= SYNC_WORD;
                            tx_bit  <= SYNC_WORD[7];
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                            tx_bit  <= !tx_bit;
                        end
                    end
                end
                ST_SYNC: begin
                    if (bit_end) begin
                        if (bit_cnt == BYTE_LAST) begin
                            state   <= ST_LEN;
                            bit_cnt <= '0;
                            shreg   <= len_r;
                            tx_bit  <= len_r[7];
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                            shreg   <= {shreg[6:0], 1'b0};
                            tx_bit  <= shreg[6];
                        end
                    end
                end
                ST_LEN, ST_PAY: begin
                    if (bit_end) begin
                        if (bit_cnt == BYTE_LAST) begin
                            bit_cnt <= '0;
                            if (at_boundary && have_byte) begin
                                state   <= ST_PAY;
                                shreg   <= next_byte;
                                tx_bit  <= next_byte[7];
                                pay_cnt <= pay_cnt + 8'd1;
                            end else begin
                                state  <= ST_GUARD;
                                tx_bit <= 1'b0;
                                if (at_boundary) begin
                                    underrun <= 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                            shreg   <= {shreg[6:0], 1'b0};
                            tx_bit  <= shreg[6];
                        end
                    end
                end
                ST_GUARD: begin
                    if (bit_end) begin
                        if (bit_cnt == GUARD_LAST) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            tx_en   <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
